// File: rtl/fg_dac_spi_tx.sv
// SPI DAC output stage: serialises each signed sample MSB-first under an active-low
// chip select, with a one-deep pending buffer and an overrun pulse for dropped samples.
module fg_dac_spi_tx #(
    parameter int BITWIDTH      = 16,
    parameter int CLK_DIV       = 2,
    parameter int CS_GAP        = 2,
    parameter int OFFSET_BINARY = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [BITWIDTH-1:0] data_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                overrun_o,
    output logic                sclk_o,
    output logic                mosi_o,
    output logic                cs_n_o
);

    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} state_t;

    function automatic logic [BITWIDTH-1:0] convert(input logic [BITWIDTH-1:0] d);
        logic [BITWIDTH-1:0] w;
        w = d;
        if (OFFSET_BINARY != 0) w[BITWIDTH-1] = ~d[BITWIDTH-1];
        return w;
    endfunction

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [BITWIDTH-1:0] word;
    logic [BITWIDTH-1:0] pend_word;
    logic                pend_valid;

    logic                store;
    logic [BITWIDTH-1:0] launch_word;

    // A strobe is buffered unless it launches directly from an empty IDLE.
    always_comb begin
        store       = start_i && ((state != IDLE) || pend_valid);
        launch_word = pend_valid ? pend_word : convert(data_i);
    end

    // NOTE: every register here, including the pending buffer, is cleared by reset so a
    // stale sample can never launch after an aborted frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            word       <= '0;
            pend_word  <= '0;
            pend_valid <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            overrun_o  <= 1'b0;
            sclk_o     <= 1'b0;
            mosi_o     <= 1'b0;
            cs_n_o     <= 1'b1;
        end else begin
            done_o    <= 1'b0;
            overrun_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (pend_valid || start_i) begin
                        word       <= launch_word;
                        mosi_o     <= launch_word[BITWIDTH-1];
                        pend_valid <= 1'b0;
                        cs_n_o     <= 1'b0;
                        busy_o     <= 1'b1;
                        cnt        <= '0;
                        bit_cnt    <= BIT_W'(BITWIDTH - 1);
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == DIV_LAST) begin
                        cnt    <= '0;
                        sclk_o <= 1'b1;
                        state  <= HIGH;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (cnt == DIV_LAST) begin
                        cnt    <= '0;
                        sclk_o <= 1'b0;
                        state  <= LOW;
                        // Next bit is presented on the falling edge, half a period before capture.
                        if (bit_cnt != '0) mosi_o <= word[bit_cnt - 1'b1];
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                LOW: begin
                    if (cnt == DIV_LAST) begin
                        cnt <= '0;
                        if (bit_cnt == '0) begin
                            cs_n_o <= 1'b1;
                            mosi_o <= 1'b0;
                            done_o <= 1'b1;
                            state  <= GAP;
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                            sclk_o  <= 1'b1;
                            state   <= HIGH;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt    <= '0;
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            // Placed after the FSM so a same-cycle store wins over the IDLE clear.
            if (store) begin
                pend_word  <= convert(data_i);
                pend_valid <= 1'b1;
                overrun_o  <= pend_valid && (state != IDLE);
            end
        end
    end

endmodule

// File: doc/fg_dac_spi_tx.md
Name: fg_dac_spi_tx

Overview:
Downstream output stage of the function generator. It takes each limited, output-enabled signed sample and serialises it to an external SPI DAC, with MSB first, an active-low chip select and a programmable SCLK rate. A one-deep pending buffer absorbs a sample strobe that arrives while a frame is in flight. An overrun pulse reports any sample that is dropped.

Parameters:
BITWIDTH, 16, sample width and SPI frame length in bits
CLK_DIV, 2, clk_i cycles per SCLK half-period; legal range is 1 or more
CS_GAP, 2, minimum number of clk_i cycles cs_n_o stays high between frames; legal range is 1 or more
OFFSET_BINARY, 1, 1 = invert the sample MSB before sending (two's complement to offset binary); 0 = send the raw two's-complement value

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous, active-high reset
start_i  in  1  one-cycle sample strobe; data_i is valid in the same cycle
data_i  in  BITWIDTH  signed sample coming from the limiter output
busy_o  out  1  high while a frame or the CS gap is in progress
done_o  out  1  one-cycle pulse when a frame completes
overrun_o  out  1  one-cycle pulse when the pending sample is overwritten
sclk_o  out  1  SPI clock; idles low; the DAC samples on the rising edge
mosi_o  out  1  SPI data
cs_n_o  out  1  SPI chip select, active low

Behaviour:
- One clock domain. Reset is synchronous and active-high. All outputs are registered.
- Reset values: cs_n_o=1, sclk_o=0, mosi_o=0, busy_o=0, done_o=0, overrun_o=0. The pending buffer is cleared and the FSM goes to IDLE.
- Reset mid-frame aborts the frame on the next edge. No done_o pulse is produced.
- Word conversion happens at capture: word = OFFSET_BINARY ? {~data[MSB], data[MSB-1:0]} : data.
- The source of the captured data depends on the path: start_i accepted in IDLE captures data_i directly; a launch from pending captures the pending word.
- FSM states: IDLE, SETUP, HIGH, LOW, GAP. A divider counter runs 0..CLK_DIV-1. A bit counter runs BITWIDTH-1 down to 0.
- IDLE:
  - If pending is valid, launch the pending word and clear pending.
  - Otherwise, if start_i is high, launch data_i.
  - If pending is valid and start_i is high in the same cycle, the pending word launches and data_i goes into pending.
  - A launch goes to SETUP.
- SETUP (CLK_DIV cycles): cs_n_o=0, sclk_o=0, mosi_o=word[BITWIDTH-1].
- HIGH (CLK_DIV cycles): sclk_o=1; mosi_o is stable.
- LOW (CLK_DIV cycles): sclk_o=0.
  - If the bit counter is above 0, mosi_o moves to the next lower bit on entry and the FSM returns to HIGH.
  - If the bit counter is 0, mosi_o holds and the FSM goes to GAP.
- GAP (CS_GAP cycles): cs_n_o=1, sclk_o=0, mosi_o=0. done_o pulses in the first GAP cycle. The FSM then returns to IDLE.
- cs_n_o low duration per frame = CLK_DIV*(1+2*BITWIDTH) cycles.
- First cs_n_o low cycle = the cycle after the accept.
- Minimum start-to-start period without pending = CLK_DIV*(1+2*BITWIDTH) + CS_GAP + 1 cycles.
- busy_o is high from the cycle after the accept through the last GAP cycle. busy_o does not reflect pending occupancy.
- start_i while not in IDLE:
  - If pending is empty, the converted data_i is stored in pending.
  - If pending is full, it is overwritten with the new word and overrun_o pulses for 1 cycle (the newest sample wins).
- A pending word launches in the IDLE cycle right after GAP. The gap between frames is therefore CS_GAP+1 cycles with cs_n_o high.
- No SCLK edges occur while cs_n_o=1.

Test Plan:
- Basic frame: BITWIDTH=16, CLK_DIV=2, OFFSET_BINARY=1, start_i with data_i=16'h1234 -> rising-edge capture = 16'h9234. cs_n_o low for exactly 66 cycles starting 1 cycle after start. 16 sclk_o rising edges. done_o pulses once at the cs_n_o rising edge.
- Extremes: data_i=-32768 -> 16'h0000; data_i=32767 -> 16'hFFFF; data_i=0 -> 16'h8000. With OFFSET_BINARY=0 and data_i=-1 -> 16'hFFFF.
- Pending: start A=100, then start B=200 10 cycles later (busy) -> frame A, then cs_n_o high for CS_GAP+1=3 cycles, then frame B. No overrun_o.
- Overrun: start A, then start B and start C both during frame A -> frames A then C. B is never sent. overrun_o pulses exactly once, in the cycle C is accepted.
- Reset mid-frame: assert rst_i during bit 7 -> next cycle cs_n_o=1, sclk_o=0, busy_o=0, no done_o, pending cleared. A fresh start then sends a correct full frame.
- CLK_DIV=1, CS_GAP=1, back-to-back pending -> cs_n_o low for 33 cycles per frame, 2 high cycles between frames, bits match the input.
